instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Sequences the byte-addressed, synchronous-read instruction ROM for the core front end.
//  Owns the PC and issues one word read per cycle, stepping PC by 4.
//  Buffers returned words with their PC in a small prefetch FIFO and hands them to decode
//  over a valid/ready interface; absorbs decode stalls and branch/jump redirects.
// PARAMETERS
//  ADDR_W     32    PC / ROM address width
//  ROM_BYTES  1024  ROM size in bytes; PC wraps modulo this (power of 2)
//  RESET_PC   0     PC loaded on reset
//  DEPTH      4     prefetch FIFO entries (power of 2, >=2)
// PORTS
//  clock           in   1       rising-edge clock
//  reset           in   1       synchronous, active-high reset
//  run             in   1       1 = fetch enabled; 0 = stop issuing (FIFO still drains)
//  redirect        in   1       taken branch/jump this cycle
//  redirect_pc     in   ADDR_W  new fetch target
//  rom_address     out  ADDR_W  byte address to ROM (registered)
//  rom_instruction in   32      ROM word, valid 1 cycle after rom_address is sampled
//  instr_valid     out  1       FIFO head valid
//  instr_ready     in   1       decode accepts head
//  instr           out  32      head instruction word
//  instr_pc        out  ADDR_W  PC of head instruction
//  busy            out  1       read in flight or FIFO non-empty
// BEHAVIOUR
//  Reset: pc=RESET_PC, rom_address=RESET_PC, FIFO empty, inflight=0, state=IDLE;
//   instr_valid=0, instr=0, instr_pc=0, busy=0. Reset mid-operation discards everything.
//  FSM: IDLE -> RUN when run=1; RUN -> IDLE when run=0 (in-flight read still captured).
//   Redirect is legal in either state and does not change state.
//  Issue (RUN, no redirect): when count+inflight < DEPTH: rom_address<=pc, pc<=pc+4,
//   inflight<=1 tagged with issued pc; else hold (no issue) and inflight<=0.
//   Credit is conservative: a same-cycle pop does not free a slot for that cycle's issue.
//  Capture: cycle after issue, rom_instruction with its tag is pushed into the FIFO.
//  Latency: issue at cycle N -> push at N+1 -> instr_valid at N+2. Steady state 1 instr/cycle
//   with instr_ready held 1.
//  Handshake: transfer when instr_valid & instr_ready. instr/instr_pc stable while
//   instr_valid=1 and instr_ready=0. Pop on empty: no effect. Push+pop same cycle:
//   count unchanged, order preserved.
//  Redirect (priority over all issue/capture): pc<=redirect_pc & ~3 (low bits forced 0),
//   FIFO flushed, in-flight read squashed (its data never pushed), no issue that cycle.
//   A transfer completing in the redirect cycle is valid and counts; flush applies after.
//   First issue at the target occurs the following cycle (if run=1).
//  Wrap: pc arithmetic modulo ROM_BYTES; pc = ROM_BYTES-4 is followed by 0.
//  Full: never overflows by construction; a push into a full FIFO is an assertion failure.
//  busy = inflight | (count != 0).
// STRUCTURE
//  Package fetch_pkg: INSTR_BYTES=4, fetch_state_t enum {IDLE, RUN}, fetch_entry_t
//   struct {pc, word}.
//  Sub-module fetch_fifo (DEPTH x fetch_entry_t, push/pop/flush, count output);
//   instr_fetch_ctrl holds PC, FSM, inflight tag, credit logic.
//  Bench uses a behavioural 1-cycle ROM model returning word = {16'hA5A5, addr[15:0]}.
// TESTING
//  Reset, run=1, ready=1: rom_address 0,4,8,..; instr_valid first at cycle 2; instr_pc 0,4,8,.. back-to-back.
//  ready=0 for 10 cycles: issues stop once count+inflight=4; FIFO holds pc 0..C; release -> 0,4,8,C,10 in order, no gap/dup.
//  Redirect to 0x3E with FIFO holding 3 entries: FIFO empties; next issue 0x3C; next instr_pc 0x3C; squashed word never appears.
//  Redirect with instr_valid&ready same cycle: head (pc X) counted once; next delivered pc = target.
//  pc reaches 0x3FC (ROM_BYTES=1024): next issued address 0x000, instr_pc sequence 0x3F8,0x3FC,0x000.
//  run 1->0 mid-stream: one in-flight word still delivered, no further issues, busy falls after drain; reset mid-stream -> all outputs 0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   INSTR_BYTES   : bytes per instruction word (PC step)
//   PC_W          : PC width carried in a prefetch entry
//   fetch_state_t : fetch mode, IDLE (no issue) or RUN (issuing reads)
//   fetch_entry_t : one prefetched instruction with the PC it was read from
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int PC_W        = 32;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     word;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched words together with their PCs.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   flush        : discard all entries (a push in the same cycle is dropped)
//   push         : write push_entry at the tail
//   push_entry   : entry to write
//   pop          : remove the head; ignored when empty
//   head         : current head entry (contents undefined when count == 0)
//   count        : number of valid entries, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);

   always_ff @(posedge clock) begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         // Simultaneous push and pop leaves the occupancy unchanged.
         if (push && !do_pop)      count <= count + CNT_W'(1);
         else if (!push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // NOTE: storage is deliberately not reset; validity comes from count,
   // and leaving the array unreset lets it map onto plain RAM cells.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];

   // The fetch controller's credit check must make this unreachable.
   push_into_full: assert property (@(posedge clock) disable iff (reset)
      push |-> (count != CNT_W'(DEPTH)));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one ROM word read per
// cycle, buffers returned words in a prefetch FIFO and presents them to
// decode over valid/ready. Handles decode stalls and branch/jump redirects.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   run             : 1 = issue reads; 0 = stop issuing (FIFO still drains)
//   redirect        : taken branch/jump; redirect_pc is the new target
//   rom_address     : registered byte address to the ROM
//   rom_instruction : ROM word for the address presented in the prior cycle
//   instr_valid/instr_ready : decode handshake; instr/instr_pc is the head
//   busy            : a read is in flight or the FIFO holds entries
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                ROM_BYTES = 1024,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                DEPTH     = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [31:0]       rom_instruction,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              busy
);

   localparam int                CNT_W      = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] PC_MASK    = ADDR_W'(ROM_BYTES - 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

   fetch_state_t     state;
   fetch_state_t     next_state;
   logic             fetch_en;
   logic             credit_ok;
   logic             issue;
   logic [ADDR_W-1:0] pc;
   logic             inflight;
   logic             push;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;
   logic [CNT_W-1:0] fifo_count;

   // Mode FSM. Fetch is enabled in the same cycle run rises, so the first
   // read leaves right out of IDLE rather than one cycle later.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned (which would infer a latch).
      next_state = state;
      fetch_en   = 1'b0;
      unique case (state)
         IDLE: if (run) begin
            next_state = RUN;
            fetch_en   = 1'b1;
         end
         RUN: if (run) fetch_en = 1'b1;
              else     next_state = IDLE;
      endcase
   end

   // Conservative credit: registered occupancy only, so a pop in this cycle
   // never frees a slot for this cycle's issue.
   assign credit_ok = (fifo_count + CNT_W'(inflight)) < CNT_W'(DEPTH);
   assign issue     = fetch_en && !redirect && credit_ok;

   // The in-flight read's tag is rom_address itself: it holds the issued PC
   // until the word comes back. A redirect squashes that word.
   assign push            = inflight && !redirect;
   assign push_entry.pc   = PC_W'(rom_address);
   assign push_entry.word = rom_instruction;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         rom_address <= RESET_PC;
         inflight    <= 1'b0;
      end else begin
         state <= next_state;
         if (redirect) begin
            pc       <= redirect_pc & ALIGN_MASK;
            inflight <= 1'b0;
         end else if (issue) begin
            rom_address <= pc;
            pc          <= (pc + ADDR_W'(INSTR_BYTES)) & PC_MASK;
            inflight    <= 1'b1;
         end else begin
            inflight <= 1'b0;
         end
      end
   end

   // A transfer in the redirect cycle still pops; the flush applies after it.
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_entry (push_entry),
      .pop        (instr_ready),
      .head       (head),
      .count      (fifo_count)
   );

   // Head fields are forced to zero when empty so stale RAM never shows.
   assign instr_valid = (fifo_count != '0);
   assign instr       = instr_valid ? head.word : '0;
   assign instr_pc    = instr_valid ? ADDR_W'(head.pc) : '0;
   assign busy        = inflight || instr_valid;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a queue-based model of the
// prefetch behaviour is compared every cycle, and directed scenarios pin
// the model with hand-computed delivery sequences and output values.
module tb_instr_fetch_ctrl;

   localparam int DEPTH     = 4;
   localparam int ROM_BYTES = 1024;

   logic        clock = 1'b0;
   logic        reset;
   logic        run;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] rom_address;
   logic [31:0] rom_instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] dut_log [$];
   logic [31:0] exp_q   [$];

   // model state
   logic [31:0] m_q [$];
   logic        m_inflight = 1'b0;
   logic [31:0] m_addr     = '0;
   logic [31:0] m_pc       = '0;
   logic        m_live     = 1'b0;
   int          m_occ;

   always #5 clock = ~clock;

   instr_fetch_ctrl #(
      .ADDR_W(32), .ROM_BYTES(ROM_BYTES), .RESET_PC(32'h0), .DEPTH(DEPTH)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .run             (run),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .rom_address     (rom_address),
      .rom_instruction (rom_instruction),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .busy            (busy)
   );

   // ROM: the controller's registered rom_address is the ROM's address
   // register, so the word is on the bus the cycle after the address edge.
   assign rom_instruction = {16'hA5A5, rom_address[15:0]};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
      step(2);
      reset = 1'b0;
      dut_log.delete();
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, 32'(dut_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < dut_log.size())
            check($sformatf("%s[%0d]", name, i), dut_log[i], exp_q[i]);
   endtask

   // Delivered instructions as seen at the DUT handshake.
   always @(posedge clock)
      if (!reset && instr_valid && instr_ready) dut_log.push_back(instr_pc);

   // Behavioural model: a queue of fetched PCs plus one outstanding read.
   always @(posedge clock) begin
      if (reset) begin
         m_q.delete();
         m_inflight = 1'b0;
         m_addr     = 32'h0;
         m_pc       = 32'h0;
         m_live     = 1'b1;
      end else begin
         m_occ = m_q.size() + int'(m_inflight);
         if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
         if (redirect) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc       = redirect_pc & ~32'h3;
         end else begin
            if (m_inflight) m_q.push_back(m_addr);
            if (run && m_occ < DEPTH) begin
               m_addr     = m_pc;
               m_pc       = (m_pc + 32'd4) % ROM_BYTES;
               m_inflight = 1'b1;
            end else begin
               m_inflight = 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (m_live) begin
         check("cmp_rom_address", rom_address, m_addr);
         check("cmp_instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
         check("cmp_instr_pc", instr_pc, (m_q.size() != 0) ? m_q[0] : 32'h0);
         check("cmp_instr", instr,
               (m_q.size() != 0) ? {16'hA5A5, m_q[0][15:0]} : 32'h0);
         check("cmp_busy", 32'(busy), 32'(m_inflight || m_q.size() != 0));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int waited;
      reset = 1'b1; run = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

      // Reset values and streaming with ready held high.
      step(2);
      check("rst_rom_address", rom_address, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0; run = 1'b1; instr_ready = 1'b1; dut_log.delete();
      step(1);
      check("s1_c1_valid", 32'(instr_valid), 32'h0);
      check("s1_c1_rom", rom_address, 32'h0);
      step(1);
      check("s1_c2_valid", 32'(instr_valid), 32'h1);
      check("s1_c2_pc", instr_pc, 32'h0);
      check("s1_c2_instr", instr, 32'hA5A5_0000);
      check("s1_c2_rom", rom_address, 32'h4);
      step(8);
      exp_q = {};
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      check_log("s1_stream");

      // Decode stall: FIFO fills to 0..C, then drains in order.
      do_reset();
      run = 1'b1;
      step(10);
      check("s2_held_len", 32'(dut_log.size()), 32'h0);
      check("s2_held_rom", rom_address, 32'hC);
      check("s2_held_pc", instr_pc, 32'h0);
      check("s2_held_busy", 32'(busy), 32'h1);
      instr_ready = 1'b1;
      step(8);
      exp_q = {};
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      check_log("s2_release");

      // Redirect to an unaligned target with three entries buffered.
      do_reset();
      run = 1'b1;
      step(4);
      redirect = 1'b1; redirect_pc = 32'h3E;
      step(1);
      redirect = 1'b0; instr_ready = 1'b1;
      check("s3_flush_valid", 32'(instr_valid), 32'h0);
      check("s3_flush_busy", 32'(busy), 32'h0);
      check("s3_flush_rom", rom_address, 32'hC);
      step(1);
      check("s3_issue_rom", rom_address, 32'h3C);
      check("s3_issue_valid", 32'(instr_valid), 32'h0);
      step(1);
      check("s3_head_pc", instr_pc, 32'h3C);
      check("s3_head_instr", instr, 32'hA5A5_003C);
      step(2);
      exp_q = {32'h3C, 32'h40};
      check_log("s3_after");

      // Redirect in the same cycle as a completed transfer.
      do_reset();
      run = 1'b1; instr_ready = 1'b1;
      step(4);
      check("s4_head_before", instr_pc, 32'h8);
      redirect = 1'b1; redirect_pc = 32'h100;
      step(1);
      redirect = 1'b0;
      step(4);
      exp_q = {32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
      check_log("s4_seq");

      // PC wrap at the top of the ROM.
      do_reset();
      run = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h3F8;
      step(1);
      redirect = 1'b0;
      step(1);
      check("s5_rom_3f8", rom_address, 32'h3F8);
      step(1);
      check("s5_rom_3fc", rom_address, 32'h3FC);
      step(1);
      check("s5_rom_wrap", rom_address, 32'h0);
      step(3);
      exp_q = {32'h3F8, 32'h3FC, 32'h0, 32'h4};
      check_log("s5_wrap");

      // run falls mid-stream: the outstanding read is still delivered.
      do_reset();
      run = 1'b1; instr_ready = 1'b1;
      step(5);
      run = 1'b0;
      check("s6_busy_at_stop", 32'(busy), 32'h1);
      waited = 0;
      while (busy && waited < 20) begin
         step(1);
         waited++;
      end
      check("s6_drain_cycles", 32'(waited), 32'h2);
      exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      check_log("s6_drain");
      check("s6_rom_hold", rom_address, 32'h10);
      step(3);
      check("s6_no_issue_len", 32'(dut_log.size()), 32'h5);
      check("s6_no_issue_rom", rom_address, 32'h10);

      // Reset in the middle of a stream.
      run = 1'b1;
      step(4);
      reset = 1'b1;
      step(1);
      check("s7_rst_valid", 32'(instr_valid), 32'h0);
      check("s7_rst_instr", instr, 32'h0);
      check("s7_rst_pc", instr_pc, 32'h0);
      check("s7_rst_busy", 32'(busy), 32'h0);
      check("s7_rst_rom", rom_address, 32'h0);
      reset = 1'b0;
      step(1);
      check("s7_c1_rom", rom_address, 32'h0);
      check("s7_c1_valid", 32'(instr_valid), 32'h0);
      step(1);
      check("s7_c2_rom", rom_address, 32'h4);
      check("s7_c2_valid", 32'(instr_valid), 32'h1);
      check("s7_c2_pc", instr_pc, 32'h0);

      run = 1'b0;
      step(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
